muldiv_unit: RTL

//  Multi-cycle RV32M execute unit (MUL/MULH/MULHSU/MULHU/DIV/DIVU/REM/REMU) in the EX stage.

---
 rtl/muldiv_unit_pkg.sv | 34 +++
 rtl/muldiv_unit_if.sv | 26 ++
 rtl/muldiv_unit_div_core.sv | 50 +++++
 rtl/muldiv_unit.sv | 127 ++++++++++++
 4 files changed

// File: rtl/muldiv_unit_pkg.sv
// Shared constants and types for the RV32M multiply/divide execute unit:
// funct3 op codes, FSM state encoding and M-extension decode helper.
package muldiv_unit_pkg;

  localparam int XLEN  = 32;
  localparam int CNT_W = $clog2(XLEN);

  localparam logic [2:0] F3_MUL    = 3'b000;
  localparam logic [2:0] F3_MULH   = 3'b001;
  localparam logic [2:0] F3_MULHSU = 3'b010;
  localparam logic [2:0] F3_MULHU  = 3'b011;
  localparam logic [2:0] F3_DIV    = 3'b100;
  localparam logic [2:0] F3_DIVU   = 3'b101;
  localparam logic [2:0] F3_REM    = 3'b110;
  localparam logic [2:0] F3_REMU   = 3'b111;

  localparam logic [6:0] OPCODE_RTYPE = 7'b0110011;
  localparam logic [6:0] FUNCT7_M     = 7'b0000001;

  localparam logic [XLEN-1:0] INT_MIN = {1'b1, {(XLEN-1){1'b0}}};

  typedef enum logic [1:0] {
    MD_IDLE = 2'd0,
    MD_MUL  = 2'd1,
    MD_DIV  = 2'd2,
    MD_DONE = 2'd3
  } md_state_t;

  // Used by the decoder to steer R-type instructions with funct7=0000001 here.
  function automatic logic is_m_op(input logic [6:0] opcode, input logic [6:0] funct7);
    return (opcode == OPCODE_RTYPE) && (funct7 == FUNCT7_M);
  endfunction

endpackage

// File: rtl/muldiv_unit_if.sv
// EX-stage handshake between the pipeline (master) and the multiply/divide unit (slave).
interface muldiv_unit_if;
  import muldiv_unit_pkg::*;

  logic            start;
  logic            kill;
  logic            ex_advance;
  logic [2:0]      funct3;
  logic [XLEN-1:0] op_a;
  logic [XLEN-1:0] op_b;
  logic [XLEN-1:0] result;
  logic            result_valid;
  logic            stall;
  logic            busy;

  modport master (
    output start, kill, ex_advance, funct3, op_a, op_b,
    input  result, result_valid, stall, busy
  );

  modport slave (
    input  start, kill, ex_advance, funct3, op_a, op_b,
    output result, result_valid, stall, busy
  );

endinterface

// File: rtl/muldiv_unit_div_core.sv
// Iterative restoring radix-2 divider on unsigned magnitudes, one quotient bit per step.
// quotient/remainder present the values the current step will produce.
module muldiv_unit_div_core
  import muldiv_unit_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic             step,
  input  logic [XLEN-1:0]  dividend,
  input  logic [XLEN-1:0]  divisor,
  output logic [XLEN-1:0]  quotient,
  output logic [XLEN-1:0]  remainder,
  output logic [CNT_W-1:0] count
);

  logic [XLEN-1:0]  rem_q;
  logic [XLEN-1:0]  quo_q;
  logic [XLEN-1:0]  dsr_q;
  logic [CNT_W-1:0] cnt_q;
  logic [XLEN:0]    shifted;
  logic [XLEN:0]    diff;

  // Dividend bits shift out of the quotient register into the partial remainder;
  // a borrow in the extra top bit means the trial subtraction must be undone.
  assign shifted   = {rem_q, quo_q[XLEN-1]};
  assign diff      = shifted - {1'b0, dsr_q};
  assign remainder = diff[XLEN] ? shifted[XLEN-1:0] : diff[XLEN-1:0];
  assign quotient  = {quo_q[XLEN-2:0], ~diff[XLEN]};
  assign count     = cnt_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rem_q <= '0;
      quo_q <= '0;
      dsr_q <= '0;
      cnt_q <= '0;
    end else if (load) begin
      rem_q <= '0;
      quo_q <= dividend;
      dsr_q <= divisor;
      cnt_q <= '0;
    end else if (step) begin
      rem_q <= remainder;
      quo_q <= quotient;
      cnt_q <= cnt_q + CNT_W'(1);
    end
  end

endmodule

// File: rtl/muldiv_unit.sv
// Multi-cycle RV32M execute unit: stalls the front of the pipe while an op is in
// flight and holds a registered result until the EX/MEM register takes it.
module muldiv_unit
  import muldiv_unit_pkg::*;
(
  input  logic         clk,
  input  logic         rst,
  muldiv_unit_if.slave bus
);

  md_state_t        state, state_next;
  logic [XLEN-1:0]  result_q, result_next;
  logic             rem_sel_q, q_neg_q, r_neg_q;
  logic             latch;
  logic             go;
  logic             div_load, div_step;
  logic [XLEN-1:0]  div_quo, div_rem;
  logic [CNT_W-1:0] div_count;

  assign go = bus.start & ~bus.kill;

  // Products are formed from the live operands in the issue cycle, so MUL* costs one stall cycle.
  logic                     a_sext, b_sext;
  logic signed [2*XLEN-1:0] mul_a, mul_b, product;
  assign a_sext  = (bus.funct3 == F3_MULH) || (bus.funct3 == F3_MULHSU);
  assign b_sext  = (bus.funct3 == F3_MULH);
  assign mul_a   = {{XLEN{a_sext & bus.op_a[XLEN-1]}}, bus.op_a};
  assign mul_b   = {{XLEN{b_sext & bus.op_b[XLEN-1]}}, bus.op_b};
  assign product = mul_a * mul_b;

  logic            div_signed, a_neg, b_neg, div_zero, div_ovf;
  logic [XLEN-1:0] mag_a, mag_b, quo_fix, rem_fix;
  assign div_signed = ~bus.funct3[0];
  assign a_neg      = div_signed & bus.op_a[XLEN-1];
  assign b_neg      = div_signed & bus.op_b[XLEN-1];
  assign mag_a      = a_neg ? -bus.op_a : bus.op_a;
  assign mag_b      = b_neg ? -bus.op_b : bus.op_b;
  assign div_zero   = (bus.op_b == '0);
  assign div_ovf    = div_signed && (bus.op_a == INT_MIN) && (bus.op_b == '1);

  assign quo_fix = q_neg_q ? -div_quo : div_quo;
  assign rem_fix = r_neg_q ? -div_rem : div_rem;

  muldiv_unit_div_core u_div_core (
    .clk       (clk),
    .rst       (rst),
    .load      (div_load),
    .step      (div_step),
    .dividend  (mag_a),
    .divisor   (mag_b),
    .quotient  (div_quo),
    .remainder (div_rem),
    .count     (div_count)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= MD_IDLE;
      result_q  <= '0;
      rem_sel_q <= 1'b0;
      q_neg_q   <= 1'b0;
      r_neg_q   <= 1'b0;
    end else begin
      state    <= state_next;
      result_q <= result_next;
      if (latch) begin
        rem_sel_q <= bus.funct3[1];
        q_neg_q   <= a_neg ^ b_neg;
        r_neg_q   <= a_neg;
      end
    end
  end

  always_comb begin
    state_next  = state;
    result_next = result_q;
    latch       = 1'b0;
    div_load    = 1'b0;
    div_step    = 1'b0;
    case (state)
      MD_IDLE: begin
        if (go) begin
          latch = 1'b1;
          if (!bus.funct3[2]) begin
            result_next = (bus.funct3 == F3_MUL) ? product[XLEN-1:0] : product[2*XLEN-1:XLEN];
            state_next  = MD_DONE;
          end else if (div_zero) begin
            result_next = bus.funct3[1] ? bus.op_a : '1;
            state_next  = MD_DONE;
          end else if (div_ovf) begin
            result_next = bus.funct3[1] ? '0 : INT_MIN;
            state_next  = MD_DONE;
          end else begin
            div_load   = 1'b1;
            state_next = MD_DIV;
          end
        end
      end
      MD_MUL: state_next = MD_DONE;
      MD_DIV: begin
        div_step = 1'b1;
        if (div_count == CNT_W'(XLEN-1)) begin
          result_next = rem_sel_q ? rem_fix : quo_fix;
          state_next  = MD_DONE;
        end
      end
      MD_DONE: begin
        if (bus.ex_advance) state_next = MD_IDLE;
      end
      default: state_next = MD_IDLE;
    endcase
    // A flushed instruction must leave no trace, whatever state it reached.
    if (bus.kill) begin
      state_next  = MD_IDLE;
      result_next = result_q;
      latch       = 1'b0;
      div_load    = 1'b0;
      div_step    = 1'b0;
    end
  end

  assign bus.result       = result_q;
  assign bus.result_valid = (state == MD_DONE);
  assign bus.busy         = (state != MD_IDLE);
  assign bus.stall        = go & (state != MD_DONE);

endmodule
